// File: rtl/ysyx_25060170_lsu_wb.sv
// LSU + write-back: takes one EXU instruction, runs its memory access, retires it to the GPR file.
// Ports: in_* from EXU (valid/ready), mem_req_*/mem_rsp_* to memory, wb_*/done/err to GPR file and retire logic.
module ysyx_25060170_lsu_wb #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_result,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_rd,
  input  logic              in_regw,
  input  logic [1:0]        in_regs,
  input  logic              in_ren,
  input  logic              in_wen,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [XLEN-1:0]   wb_data,
  output logic              done,
  output logic [1:0]        err
);

  localparam int SW = XLEN / 8;
  localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    WB
  } state_t;

  state_t          state;
  logic [15:0]     cnt;
  logic [XLEN-1:0] q_addr;
  logic [XLEN-1:0] q_pc;
  logic [XLEN-1:0] q_wdata;
  logic [XLEN-1:0] q_rdata;
  logic [4:0]      q_rd;
  logic            q_regw;
  logic [1:0]      q_regs;
  logic            q_ld;
  logic            q_we;
  logic [2:0]      q_f3;
  logic [1:0]      q_err;

  logic            mem;
  logic            mis;
  logic [1:0]      off;
  logic [15:0]     lane;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] wb_sel;
  logic [XLEN-1:0] st_wdata;
  logic [SW-1:0]   st_wstrb;

  assign mem = in_ren | in_wen;

  // funct3[1] set means a word access (lw, and 3/6/7 alias to lw)
  always_comb begin
    mis = 1'b0;
    if (in_funct3[1])
      mis = in_result[1:0] != 2'b00;
    else if (in_funct3[0])
      mis = in_result[0];
  end

  assign off = q_addr[1:0];

  always_comb begin
    st_wdata = q_wdata;
    st_wstrb = '0;
    if (q_we) begin
      if (q_f3[1]) begin
        st_wstrb = '1;
      end else if (q_f3[0]) begin
        st_wstrb = SW'(3) << off;
        st_wdata = {(XLEN/16){q_wdata[15:0]}};
      end else begin
        st_wstrb = SW'(1) << off;
        st_wdata = {SW{q_wdata[7:0]}};
      end
    end
  end

  assign lane = 16'(q_rdata >> {off, 3'b000});

  always_comb begin
    unique case (q_f3)
      3'd0:    ld_val = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'd1:    ld_val = {{(XLEN-16){lane[15]}}, lane};
      3'd4:    ld_val = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'd5:    ld_val = {{(XLEN-16){1'b0}}, lane};
      default: ld_val = q_rdata;
    endcase
  end

  always_comb begin
    unique case (q_regs)
      2'd0:    wb_sel = q_addr;
      2'd1:    wb_sel = ld_val;
      2'd2:    wb_sel = q_pc + XLEN'(4);
      default: wb_sel = '0;
    endcase
  end

  assign in_ready      = state == IDLE;
  assign mem_req_valid = state == REQ;
  assign mem_req_we    = q_we;
  assign mem_req_addr  = {q_addr[XLEN-1:2], 2'b00};
  assign mem_req_wdata = st_wdata;
  assign mem_req_wstrb = st_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      q_addr  <= '0;
      q_pc    <= '0;
      q_wdata <= '0;
      q_rdata <= '0;
      q_rd    <= '0;
      q_regw  <= 1'b0;
      q_regs  <= '0;
      q_ld    <= 1'b0;
      q_we    <= 1'b0;
      q_f3    <= '0;
      q_err   <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      done    <= 1'b0;
      err     <= '0;
    end else begin
      done  <= 1'b0;
      wb_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            q_addr  <= in_result;
            q_pc    <= in_pc;
            q_wdata <= in_wdata;
            q_rdata <= '0;
            q_rd    <= in_rd;
            q_regw  <= in_regw;
            q_regs  <= in_regs;
            q_ld    <= in_ren & ~in_wen;
            q_we    <= in_wen;
            q_f3    <= in_funct3;
            q_err   <= (mem && mis) ? 2'd1 : 2'd0;
            state   <= (mem && !mis) ? REQ : WB;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // a response on the last counted cycle still wins over timeout
          if (mem_rsp_valid) begin
            if (q_ld)
              q_rdata <= mem_rsp_rdata;
            state <= WB;
          end else if (cnt == T_LAST) begin
            q_err <= 2'd2;
            state <= WB;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WB: begin
          done    <= 1'b1;
          wb_en   <= q_regw && (q_rd != 5'd0) && (q_err == 2'd0);
          wb_addr <= q_rd;
          wb_data <= wb_sel;
          err     <= q_err;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
